// File: rtl/adc_emu_pkg.sv
// Shared encodings for the ADC emulator: pattern modes, burst FSM states and LFSR definition.
package adc_emu_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int          LFSR_W      = 10;
  localparam logic [9:0]  LFSR_SEED   = 10'h001;
  localparam int          LFSR_TAP_HI = 9;
  localparam int          LFSR_TAP_LO = 6;

  // Fibonacci x^10+x^7+1, shifting left; a nonzero seed never reaches all-zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/adc_pattern_gen.sv
// Sample pattern source: presents the sample to launch next and steps on each launch.
module adc_pattern_gen
  import adc_emu_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              sys_clk,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic [DATA_W-1:0] sample
);

  mode_e             mode_q;
  logic [DATA_W-1:0] const_q;
  logic [DATA_W-1:0] ramp_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              alt_q;

  // Pattern state is always reloaded at burst start, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (load) begin
      mode_q  <= mode_e'(mode);
      const_q <= const_val;
      ramp_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      alt_q   <= 1'b0;
    end else if (advance) begin
      ramp_q  <= ramp_q + DATA_W'(1);
      lfsr_q  <= lfsr_step(lfsr_q);
      alt_q   <= ~alt_q;
    end
  end

  always_comb begin
    sample = const_q;
    case (mode_q)
      MODE_CONST: sample = const_q;
      MODE_RAMP:  sample = ramp_q;
      MODE_LFSR:  sample = DATA_W'(lfsr_q);
      MODE_ALT:   sample = alt_q ? ~const_q : const_q;
      default:    sample = const_q;
    endcase
  end

endmodule

// File: rtl/adc_stream_emitter.sv
// Emulated 10-bit parallel ADC: divided ADC_CLK, burst-gated ADC_DTR and pattern data on ADC_D,
// controlled by a START/STOP/BUSY/DONE handshake.
module adc_stream_emitter
  import adc_emu_pkg::*;
#(
  parameter int CLK_DIV = 3,
  parameter int DATA_W  = 10,
  parameter int LEN_W   = 16
) (
  input  logic              SYS_CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic [LEN_W-1:0]  BURST_LEN,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] CONST_VAL,
  output logic              BUSY,
  output logic              DONE,
  output logic [LEN_W-1:0]  SAMPLE_CNT,
  output logic              ADC_CLK,
  output logic              ADC_DTR,
  output logic [DATA_W-1:0] ADC_D
);

  localparam int            PW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int            LO     = CLK_DIV - CLK_DIV / 2;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_LO   = PW'(LO);

  state_e            state_q, state_n;
  logic [PW-1:0]     p_q, p_n;
  logic              wrap;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              stop_q, stop_n;
  logic              live_q, live_n;
  logic              clk_q, dtr_q;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [DATA_W-1:0] d_q, d_n;
  logic              load, advance;
  logic [DATA_W-1:0] sample;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign wrap = (p_q == P_LAST);

  adc_pattern_gen #(.DATA_W(DATA_W)) u_pat (
    .sys_clk   (SYS_CLK),
    .load      (load),
    .advance   (advance),
    .mode      (MODE),
    .const_val (CONST_VAL),
    .sample    (sample)
  );

  // live marks an ADC_CLK period that carries a sample; it only changes on the launch edge.
  always_comb begin
    p_n     = wrap ? '0 : p_q + PW'(1);
    state_n = state_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    stop_n  = stop_q;
    live_n  = wrap ? 1'b0 : live_q;
    cnt_n   = cnt_q;
    len_n   = len_q;
    d_n     = d_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !done_q) begin
          state_n = ARM;
          busy_n  = 1'b1;
          cnt_n   = '0;
          len_n   = BURST_LEN;
          stop_n  = 1'b0;
          load    = 1'b1;
        end
      end
      ARM, RUN: begin
        stop_n = stop_q | STOP;
        if (wrap) begin
          if (stop_q || STOP || (state_q == RUN && len_q != '0 && cnt_q == len_q)) begin
            state_n = DRAIN;
          end else begin
            state_n = RUN;
            d_n     = sample;
            advance = 1'b1;
            live_n  = 1'b1;
            cnt_n   = sat_inc(cnt_q);
          end
        end
      end
      DRAIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      live_q  <= 1'b0;
      clk_q   <= 1'b0;
      dtr_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_n;
      p_q     <= p_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      stop_q  <= stop_n;
      live_q  <= live_n;
      clk_q   <= (p_n >= P_LO);
      dtr_q   <= (p_n >= P_LO) && live_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      d_q     <= d_n;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign SAMPLE_CNT = cnt_q;
  assign ADC_CLK    = clk_q;
  assign ADC_DTR    = dtr_q;
  assign ADC_D      = d_q;

endmodule

// File: tb/tb_adc_stream_emitter.sv
// Scoreboard bench for adc_stream_emitter with CLK_DIV=4 against a pattern reference model.
module tb_adc_stream_emitter;

  logic        SYS_CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        STOP;
  logic [15:0] BURST_LEN;
  logic [1:0]  MODE;
  logic [9:0]  CONST_VAL;
  logic        BUSY;
  logic        DONE;
  logic [15:0] SAMPLE_CNT;
  logic        ADC_CLK;
  logic        ADC_DTR;
  logic [9:0]  ADC_D;

  int errors = 0;
  int checks = 0;
  int tb_p = 0;
  int rise_cnt = 0;
  bit mon_en = 1'b0;
  logic [9:0]  exp_q[$];
  logic [15:0] done_q[$];

  adc_stream_emitter #(.CLK_DIV(4), .DATA_W(10), .LEN_W(16)) dut (
    .SYS_CLK    (SYS_CLK),
    .RESET      (RESET),
    .START      (START),
    .STOP       (STOP),
    .BURST_LEN  (BURST_LEN),
    .MODE       (MODE),
    .CONST_VAL  (CONST_VAL),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .SAMPLE_CNT (SAMPLE_CNT),
    .ADC_CLK    (ADC_CLK),
    .ADC_DTR    (ADC_DTR),
    .ADC_D      (ADC_D)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // k-th sample of a burst, straight from the pattern definitions.
  function automatic logic [9:0] model_sample(input int m, input logic [9:0] c, input int k);
    int q;
    case (m)
      0: return c;
      1: return 10'(k % 1024);
      2: begin
        q = 1;
        for (int i = 0; i < k; i++) q = ((q * 2) % 1024) + (((q / 512) + (q / 64)) % 2);
        return 10'(q);
      end
      default: return (k % 2 == 0) ? c : ~c;
    endcase
  endfunction

  task automatic push_exp(input int m, input logic [9:0] c, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(model_sample(m, c, k));
    done_q.push_back(16'(n));
  endtask

  // Phase model: the period restarts at reset and repeats every 4 cycles.
  initial forever begin
    @(posedge SYS_CLK);
    tb_p = RESET ? 0 : (tb_p + 1) % 4;
  end

  // Monitor: pops expected samples on DTR rising, expected counts on DONE.
  initial begin
    logic dtr_prev;
    int   hi_len;
    dtr_prev = 1'b0;
    hi_len   = 0;
    forever begin
      @(negedge SYS_CLK);
      if (!mon_en || RESET) begin
        dtr_prev = 1'b0;
        hi_len   = 0;
      end else begin
        chk("adc_clk_phase", 64'(ADC_CLK), 64'(tb_p >= 2));
        if (ADC_DTR && !dtr_prev) begin
          rise_cnt++;
          if (exp_q.size() == 0) chk("unexpected_sample", 64'(ADC_D), 64'h400);
          else chk("sample", 64'(ADC_D), 64'(exp_q.pop_front()));
        end
        if (ADC_DTR) hi_len++;
        else if (dtr_prev) begin
          chk("dtr_width", 64'(hi_len), 64'd2);
          hi_len = 0;
        end
        if (DONE) begin
          if (done_q.size() == 0) chk("unexpected_done", 64'(SAMPLE_CNT), 64'h10000);
          else chk("done_cnt_busy", {47'd0, BUSY, SAMPLE_CNT}, {47'd0, 1'b0, done_q.pop_front()});
        end
        dtr_prev = ADC_DTR;
      end
    end
  end

  task automatic start_burst(input logic [1:0] m, input logic [9:0] c, input logic [15:0] len,
                             input bit align);
    @(posedge SYS_CLK); #1;
    if (align) while (tb_p != 3) begin @(posedge SYS_CLK); #1; end
    MODE = m; CONST_VAL = c; BURST_LEN = len; START = 1'b1;
    @(posedge SYS_CLK); #1;
    START = 1'b0;
    MODE = 2'($urandom_range(3, 0)); CONST_VAL = 10'($urandom); BURST_LEN = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin @(negedge SYS_CLK); n++; end while (!DONE && n < budget);
    if (!DONE) chk("done_timeout", 64'(n), 64'(budget + 1));
  endtask

  task automatic wait_rises(input int target, input int budget);
    int n;
    n = 0;
    while (rise_cnt < target && n < budget) begin @(negedge SYS_CLK); n++; end
    if (rise_cnt < target) chk("rise_timeout", 64'(rise_cnt), 64'(target));
  endtask

  initial begin
    int r0, n, len;
    logic [1:0] m;
    logic [9:0] c;
    RESET = 1'b1; START = 1'b0; STOP = 1'b0; BURST_LEN = '0; MODE = '0; CONST_VAL = '0;
    repeat (2) @(posedge SYS_CLK);
    #1 RESET = 1'b0;
    mon_en = 1'b1;

    // Idle: clock runs, everything else quiet.
    for (int i = 0; i < 40; i++) begin
      @(negedge SYS_CLK);
      chk("idle_outputs", {ADC_DTR, ADC_D, BUSY, DONE, SAMPLE_CNT}, 64'd0);
    end

    // Ramp, 3 samples.
    push_exp(1, 10'h0, 3);
    start_burst(2'd1, 10'h0, 16'd3, 1'b0);
    wait_done(40);

    // LFSR, 8 samples: 001,002,004,008,010,020,040,081.
    push_exp(2, 10'h0, 8);
    start_burst(2'd2, 10'h0, 16'd8, 1'b0);
    wait_done(60);

    // Continuous constant ended by STOP after the 5th sample; a second START is ignored.
    c = 10'($urandom);
    r0 = rise_cnt;
    push_exp(0, c, 5);
    start_burst(2'd0, c, 16'd0, 1'b0);
    wait_rises(r0 + 2, 40);
    @(posedge SYS_CLK); #1 MODE = 2'd1; START = 1'b1;
    @(posedge SYS_CLK); #1 START = 1'b0;
    wait_rises(r0 + 5, 40);
    @(posedge SYS_CLK); #1 STOP = 1'b1;
    @(posedge SYS_CLK); #1 STOP = 1'b0;
    wait_done(20);

    // START captured on the wrap edge: first DTR rise comes a full period later.
    push_exp(1, 10'h0, 2);
    start_burst(2'd1, 10'h0, 16'd2, 1'b1);
    n = 0;
    do begin @(negedge SYS_CLK); n++; end while (!ADC_DTR && n < 20);
    chk("first_launch_latency", 64'(n), 64'd7);
    wait_done(30);

    // STOP while armed: no samples, DONE with count 0.
    r0 = rise_cnt;
    done_q.push_back(16'd0);
    start_burst(2'd1, 10'h0, 16'd5, 1'b0);
    STOP = 1'b1;
    @(posedge SYS_CLK); #1 STOP = 1'b0;
    wait_done(20);
    chk("arm_stop_pulses", 64'(rise_cnt), 64'(r0));

    // Reset in the middle of a long ramp burst.
    r0 = rise_cnt;
    push_exp(1, 10'h0, 100);
    start_burst(2'd1, 10'h0, 16'd100, 1'b0);
    wait_rises(r0 + 3, 40);
    @(posedge SYS_CLK); #1 RESET = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge SYS_CLK); #1 RESET = 1'b0;
    @(negedge SYS_CLK);
    chk("reset_outputs", {ADC_CLK, ADC_DTR, ADC_D, BUSY, DONE, SAMPLE_CNT}, 64'd0);
    repeat (10) @(negedge SYS_CLK);

    // Alternating after reset: 155, 2AA, 155.
    push_exp(3, 10'h155, 3);
    start_burst(2'd3, 10'h155, 16'd3, 1'b0);
    wait_done(40);

    // Random bursts.
    for (int b = 0; b < 8; b++) begin
      m   = 2'($urandom_range(3, 0));
      c   = 10'($urandom);
      len = $urandom_range(10, 1);
      push_exp(int'(m), c, len);
      repeat ($urandom_range(5, 0)) @(posedge SYS_CLK);
      start_burst(m, c, 16'(len), bit'($urandom_range(1, 0)));
      wait_done(4 * (len + 3) + 20);
    end

    repeat (10) @(negedge SYS_CLK);
    chk("samples_left", 64'(exp_q.size()), 64'd0);
    chk("dones_left", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
